// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver.
// Collects WIDTH strobed serial bits into a word, presents it with a
// valid/ack handshake, and flags a sticky overrun when a completed word
// has to be dropped because the consumer has not taken the previous one.
module serial_word_receiver #(
    parameter int WIDTH       = 8,
    parameter bit SHIFT_RIGHT = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         serial_in,
    input  logic                         bit_valid,
    input  logic                         frame_start,
    output logic [WIDTH-1:0]             data_out,
    output logic                         data_valid,
    input  logic                         data_ack,
    output logic                         busy,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count,
    output logic                         overrun
);

    localparam int CW = $clog2(WIDTH+1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    count_q;
    logic             data_valid_q;
    logic             overrun_q;

    logic [WIDTH-1:0] shift_d;    // current partial word with serial_in shifted in
    logic [WIDTH-1:0] restart_d;  // empty word with serial_in shifted in

    // Insert the incoming bit at the end chosen by SHIFT_RIGHT.
    generate
        if (SHIFT_RIGHT) begin : g_lsb_first
            assign shift_d   = {serial_in, shift_q[WIDTH-1:1]};
            assign restart_d = {serial_in, {(WIDTH-1){1'b0}}};
        end else begin : g_msb_first
            assign shift_d   = {shift_q[WIDTH-2:0], serial_in};
            assign restart_d = {{(WIDTH-1){1'b0}}, serial_in};
        end
    endgenerate

    // Receive FSM, shift register, output word, handshake and overrun flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            data_q       <= '0;
            count_q      <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // NOTE: with non-blocking assignments the last one in program order
            // wins, so a completion further down overrides this ack clear.
            if (data_valid_q && data_ack) begin
                data_valid_q <= 1'b0;
            end

            if (frame_start) begin
                // Start (or restart) a word; a strobe in the same cycle is bit 1.
                state_q <= RECV;
                shift_q <= bit_valid ? restart_d : '0;
                count_q <= bit_valid ? CW'(1) : '0;
            end else if (state_q == RECV && bit_valid) begin
                if (count_q == LAST_IDX) begin
                    state_q <= IDLE;
                    shift_q <= '0;
                    count_q <= '0;
                    if (!data_valid_q || data_ack) begin
                        data_q       <= shift_d;
                        data_valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end else begin
                    shift_q <= shift_d;
                    count_q <= count_q + CW'(1);
                end
            end
        end
    end

    // Every output is taken straight from a register.
    assign data_out   = data_q;
    assign data_valid = data_valid_q;
    assign busy       = (state_q == RECV);
    assign bit_count  = count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: one LSB-first and one MSB-first
// instance share the same stimulus; each step's expected values are
// hand-computed constants.
module tb_serial_word_receiver;

    logic       clk;
    logic       reset_n;
    logic       serial_in;
    logic       bit_valid;
    logic       frame_start;
    logic       data_ack;

    logic [7:0] r_data,  l_data;
    logic       r_valid, l_valid;
    logic       r_busy,  l_busy;
    logic [3:0] r_count, l_count;
    logic       r_ovr,   l_ovr;

    int checks = 0;
    int errors = 0;
    int rises  = 0;
    logic prev_valid = 1'b0;

    serial_word_receiver #(.WIDTH(8), .SHIFT_RIGHT(1'b1)) dut_r (
        .clk(clk), .reset_n(reset_n), .serial_in(serial_in),
        .bit_valid(bit_valid), .frame_start(frame_start),
        .data_out(r_data), .data_valid(r_valid), .data_ack(data_ack),
        .busy(r_busy), .bit_count(r_count), .overrun(r_ovr)
    );

    serial_word_receiver #(.WIDTH(8), .SHIFT_RIGHT(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .serial_in(serial_in),
        .bit_valid(bit_valid), .frame_start(frame_start),
        .data_out(l_data), .data_valid(l_valid), .data_ack(data_ack),
        .busy(l_busy), .bit_count(l_count), .overrun(l_ovr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges of the LSB-first instance's data_valid.
    always @(negedge clk) begin
        if (r_valid && !prev_valid) rises++;
        prev_valid = r_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances against the expected values.
    task automatic expect_all(input string tag, input logic [7:0] dr, input logic [7:0] dl,
                              input logic v, input logic b, input logic [3:0] c, input logic o);
        check({tag, " r.data"},  r_data,  dr);
        check({tag, " l.data"},  l_data,  dl);
        check({tag, " r.valid"}, r_valid, v);
        check({tag, " l.valid"}, l_valid, v);
        check({tag, " r.busy"},  r_busy,  b);
        check({tag, " l.busy"},  l_busy,  b);
        check({tag, " r.count"}, r_count, c);
        check({tag, " l.count"}, l_count, c);
        check({tag, " r.ovr"},   r_ovr,   o);
        check({tag, " l.ovr"},   l_ovr,   o);
    endtask

    // Apply inputs at a falling edge and advance through one rising edge.
    task automatic drive(input logic fs, input logic bv, input logic si, input logic ack);
        frame_start = fs;
        bit_valid   = bv;
        serial_in   = si;
        data_ack    = ack;
        @(negedge clk);
    endtask

    task automatic quiet();
        frame_start = 1'b0;
        bit_valid   = 1'b0;
        serial_in   = 1'b0;
        data_ack    = 1'b0;
    endtask

    // Frame pulse, then bits w[0]..w[7]; optional ack on the final strobe and
    // optional random idle gaps between strobes.
    task automatic send_word(input logic [7:0] w, input logic ack_last, input int max_gap);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, w[i], (i == 7) && ack_last);
            if (max_gap > 0 && i < 7) begin
                repeat ($urandom_range(0, max_gap)) drive(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        quiet();
    endtask

    int rises_before;
    logic [7:0] pat;

    initial begin
        reset_n = 1'b0;
        quiet();
        #1;
        expect_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic frame: bits 1,0,0,1,0,1,1,0 back to back.
        pat = 8'h69;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("start", 8'h00, 8'h00, 1'b0, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, pat[i], 1'b0);
        expect_all("seven", 8'h00, 8'h00, 1'b0, 1'b1, 4'd7, 1'b0);
        drive(1'b0, 1'b1, pat[7], 1'b0);
        quiet();
        expect_all("basic", 8'h69, 8'h96, 1'b1, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        expect_all("hold", 8'h69, 8'h96, 1'b1, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("ack", 8'h69, 8'h96, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("stray_ack", 8'h69, 8'h96, 1'b0, 1'b0, 4'd0, 1'b0);

        // Same word with random 0..5 cycle gaps between strobes.
        send_word(8'h69, 1'b0, 5);
        expect_all("gaps", 8'h69, 8'h96, 1'b1, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        quiet();

        // Abort after 5 bits; restart strobe carries bit 0 of 0xA5.
        pat = 8'hA5;
        rises_before = rises;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        expect_all("partial", 8'h69, 8'h96, 1'b0, 1'b1, 4'd5, 1'b0);
        drive(1'b1, 1'b1, pat[0], 1'b0);
        expect_all("restart", 8'h69, 8'h96, 1'b0, 1'b1, 4'd1, 1'b0);
        for (int i = 1; i < 8; i++) drive(1'b0, 1'b1, pat[i], 1'b0);
        quiet();
        expect_all("abort", 8'hA5, 8'hA5, 1'b1, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("abort valid_rises", rises - rises_before, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        quiet();

        // Overrun: 0x11 left pending, 0x22 is dropped.
        send_word(8'h11, 1'b0, 0);
        expect_all("w11", 8'h11, 8'h88, 1'b1, 1'b0, 4'd0, 1'b0);
        send_word(8'h22, 1'b0, 0);
        expect_all("overrun", 8'h11, 8'h88, 1'b1, 1'b0, 4'd0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        quiet();
        expect_all("ack11", 8'h11, 8'h88, 1'b0, 1'b0, 4'd0, 1'b1);
        send_word(8'h44, 1'b0, 0);
        expect_all("w44", 8'h44, 8'h22, 1'b1, 1'b0, 4'd0, 1'b1);
        // 0x33 completes on the same edge that acks 0x44.
        send_word(8'h33, 1'b1, 0);
        expect_all("ack_on_done", 8'h33, 8'hCC, 1'b1, 1'b0, 4'd0, 1'b1);

        // Asynchronous reset between edges, mid-word, with a word pending.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
        quiet();
        #2 reset_n = 1'b0;
        #1;
        expect_all("async_rst", 8'h00, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send_word(8'hC3, 1'b0, 0);
        expect_all("after_rst", 8'hC3, 8'hC3, 1'b1, 1'b0, 4'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        quiet();

        // Strobes in IDLE without a frame pulse change nothing.
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        quiet();
        expect_all("idle_noise", 8'hC3, 8'hC3, 1'b0, 1'b0, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-to-parallel receiver: the receiving end of the team's parallel-load, serial-out shifter chain.
- Collects WIDTH serial bits, each qualified by a strobe, into a word.
- Presents the completed word on a parallel output with a valid/ack handshake.
- Sits between a serial link (shifter chain output) and a parallel consumer; flags overrun when the consumer is too slow.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- SHIFT_RIGHT, 1, 1: each new bit enters at bit WIDTH-1 and the word shifts toward bit 0, so the first bit received ends at bit 0 (LSB-first). 0: each new bit enters at bit 0 and shifts toward the MSB, so the first bit ends at bit WIDTH-1 (MSB-first).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- serial_in  input  1  serial data bit, sampled only when bit_valid=1
- bit_valid  input  1  one-cycle strobe; qualifies serial_in
- frame_start  input  1  one-cycle pulse; begins a new word, aborting any partial word
- data_out  output  WIDTH  last completed word
- data_valid  output  1  data_out holds an unconsumed word
- data_ack  input  1  consumer accepts data_out; effective only while data_valid=1
- busy  output  1  word reception in progress
- bit_count  output  $clog2(WIDTH+1)  bits captured in the current word
- overrun  output  1  sticky: a completed word was lost

Behaviour:
- One clock, clk. reset_n is asynchronous and active-low.
- Reset (reset_n=0, takes effect immediately, no clock needed): state=IDLE; shift register, data_out, bit_count = 0; data_valid, busy, overrun = 0. Reset mid-frame discards the partial word and any pending word.
- FSM states: IDLE, RECV.
- IDLE:
  - bit_valid without frame_start is ignored.
  - frame_start=1 -> RECV; shift register and bit_count cleared.
  - If bit_valid=1 in the same cycle as frame_start, that bit is captured as bit 1 (bit_count=1 after the edge).
- RECV:
  - On each edge with bit_valid=1, serial_in is shifted in per SHIFT_RIGHT and bit_count increments.
  - Cycles with bit_valid=0 hold all state; gaps between strobes are unlimited.
- Completion, on the edge that captures bit WIDTH:
  - The completed word is written to data_out (including the bit just captured).
  - data_valid=1 and state -> IDLE.
  - bit_count resets to 0 and busy drops.
  - data_valid is therefore visible in the cycle after the final strobe.
- frame_start in RECV: abort. The partial word is discarded, bit_count restarts (at 1 if bit_valid is also 1, else 0), and the state stays RECV. data_out, data_valid and overrun are unaffected.
- Handshake:
  - data_valid stays 1 until an edge with data_ack=1, which clears it. data_out is stable while data_valid=1.
  - data_ack while data_valid=0 is ignored.
- Overrun:
  - Completion while data_valid=1 and data_ack=0: the new word is dropped, data_out keeps the old word, and overrun sets.
  - Completion while data_valid=1 and data_ack=1 in the same cycle: the new word is loaded, data_valid stays 1, and no overrun is flagged.
- overrun is sticky; it is cleared only by reset.
- busy = (state==RECV).
- bit_count never exceeds WIDTH-1 when observed.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, SHIFT_RIGHT=1: frame_start, then strobes of 1,0,0,1,0,1,1,0 on consecutive cycles -> data_out=0x69; data_valid rises the cycle after the 8th strobe; busy=0; bit_count=0.
- Same stimulus with SHIFT_RIGHT=0 -> data_out=0x96; random 0-5 idle-cycle gaps between strobes give an identical result.
- Abort: frame_start, 5 strobes, then frame_start together with a strobe, then 7 more strobes of 0xA5 (LSB-first) -> data_out=0xA5; exactly one data_valid assertion; bit_count visible as 1 after the restart edge.
- Handshake and overrun: word 0x11 completes with no ack, then word 0x22 completes -> data_out stays 0x11 and overrun=1. Ack, then send 0x33 while acking the pending word on the completion edge -> data_out=0x33, data_valid stays 1, overrun remains 1.
- Async reset: assert reset_n=0 between clock edges mid-word with data_valid=1 -> all outputs 0 before the next edge. After release, a full frame of 0xC3 is received correctly.
- Idle noise: strobes without frame_start in IDLE -> no change on any output.
